button_debounce_multi: RTL and testbench

Multi-channel debouncer with per-channel press/release pulses and long-press/auto-repeat event generation. It is the parametrised successor to the single-button counter debouncer. It sits between the FPGA push-button pins and the controller logic, so that downstream FSMs consume clean levels and single-cycle events instead of raw contacts.

---
 rtl/button_debounce_multi.sv | 170 +++++++++++++++++
 tb/tb_button_debounce_multi.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_multi.sv
// Multi-channel push-button debouncer: clean levels, press/release edges and
// long-press / auto-repeat events, one identical channel per button pin.
//
// Hold FSM states:
//   state        | meaning
//   ST_IDLE      | released, or long-press disabled
//   ST_HELD      | pressed, counting toward the long-press event
//   ST_REPEATING | long press seen, emitting periodic repeat events
module button_debounce_multi #(
   parameter int CLK_FREQ       = 50_000_000,
   parameter int STABLE_TIME_MS = 10,
   parameter int N_BUTTONS      = 4,
   parameter int ACTIVE_LOW     = 0,
   parameter int LONG_PRESS_MS  = 1000,
   parameter int REPEAT_MS      = 200
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_BUTTONS-1:0] button_in,
   output logic [N_BUTTONS-1:0] btn_level,
   output logic [N_BUTTONS-1:0] press_pulse,
   output logic [N_BUTTONS-1:0] release_pulse,
   output logic [N_BUTTONS-1:0] long_press_pulse,
   output logic [N_BUTTONS-1:0] repeat_pulse
);

   localparam int CYC_PER_MS    = CLK_FREQ / 1000;
   localparam int DB_CYCLES     = STABLE_TIME_MS * CYC_PER_MS;
   localparam int LONG_CYCLES   = LONG_PRESS_MS * CYC_PER_MS;
   localparam int REPEAT_CYCLES = REPEAT_MS * CYC_PER_MS;

   localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int HOLD_W = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;
   localparam int REP_W  = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;

   localparam logic [DB_W-1:0]   DB_TC   = DB_W'((DB_CYCLES > 1) ? DB_CYCLES - 1 : 0);
   localparam logic [HOLD_W-1:0] HOLD_TC = HOLD_W'((LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0);
   localparam logic [REP_W-1:0]  REP_TC  = REP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

   localparam bit LONG_EN   = (LONG_CYCLES > 0);
   localparam bit REPEAT_EN = (REPEAT_CYCLES > 0);

   localparam logic [N_BUTTONS-1:0] POL_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_HELD      = 2'd1,
      ST_REPEATING = 2'd2
   } hold_state_e;

   // Internal convention: 1 = pressed, regardless of pin polarity.
   logic [N_BUTTONS-1:0] btn_pol;
   assign btn_pol = button_in ^ POL_MASK;

   for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
      logic              s1_q, s1_d;
      logic              s2_q, s2_d;
      logic              level_q, level_d;
      logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
      logic              update;
      logic              press_q, press_d;
      logic              release_q, release_d;
      logic              long_q, long_d;
      logic              rep_q, rep_d;
      hold_state_e       state_q, state_d;
      logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
      logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;

      assign s1_d = btn_pol[g];
      assign s2_d = s1_q;

      always_comb begin
         level_d  = level_q;
         db_cnt_d = '0;
         update   = 1'b0;
         if (s2_q != level_q) begin
            if (db_cnt_q == DB_TC) begin
               update  = 1'b1;
               level_d = s2_q;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         press_d   = update & s2_q;
         release_d = update & ~s2_q;
      end

      // Release wins over any terminal count landing on the same edge.
      always_comb begin
         state_d    = state_q;
         hold_cnt_d = hold_cnt_q;
         rep_cnt_d  = rep_cnt_q;
         long_d     = 1'b0;
         rep_d      = 1'b0;
         if (release_d) begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (press_d && LONG_EN) begin
                     state_d    = ST_HELD;
                     hold_cnt_d = '0;
                  end
               end
               ST_HELD: begin
                  if (hold_cnt_q == HOLD_TC) begin
                     long_d    = 1'b1;
                     rep_cnt_d = '0;
                     state_d   = ST_REPEATING;
                  end else begin
                     hold_cnt_d = hold_cnt_q + 1'b1;
                  end
               end
               ST_REPEATING: begin
                  if (REPEAT_EN) begin
                     if (rep_cnt_q == REP_TC) begin
                        rep_d     = 1'b1;
                        rep_cnt_d = '0;
                     end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                     end
                  end
               end
               default: begin
                  state_d    = ST_IDLE;
                  hold_cnt_d = '0;
                  rep_cnt_d  = '0;
               end
            endcase
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            level_q    <= 1'b0;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            rep_q      <= 1'b0;
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
         end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            level_q    <= level_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            rep_q      <= rep_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
         end
      end

      assign btn_level[g]        = level_q;
      assign press_pulse[g]      = press_q;
      assign release_pulse[g]    = release_q;
      assign long_press_pulse[g] = long_q;
      assign repeat_pulse[g]     = rep_q;
   end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed bench for button_debounce_multi: vector table for debounce/edge
// timing plus hand sequences for long-press, repeat, reset and polarity.
module tb_button_debounce_multi;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn, btn_al;
   logic [3:0] lvl, prs, rls, lng, rpt;
   logic [3:0] lvl_al, prs_al, rls_al, lng_al, rpt_al;
   int         errors = 0;
   int         checks = 0;

   typedef struct {
      logic [3:0] btn;
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] rls;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   button_debounce_multi #(
      .CLK_FREQ(1000), .STABLE_TIME_MS(4), .N_BUTTONS(4),
      .ACTIVE_LOW(0), .LONG_PRESS_MS(20), .REPEAT_MS(5)
   ) dut (
      .clk(clk), .rst(rst), .button_in(btn),
      .btn_level(lvl), .press_pulse(prs), .release_pulse(rls),
      .long_press_pulse(lng), .repeat_pulse(rpt)
   );

   button_debounce_multi #(
      .CLK_FREQ(1000), .STABLE_TIME_MS(4), .N_BUTTONS(4),
      .ACTIVE_LOW(1), .LONG_PRESS_MS(20), .REPEAT_MS(5)
   ) dut_al (
      .clk(clk), .rst(rst), .button_in(btn_al),
      .btn_level(lvl_al), .press_pulse(prs_al), .release_pulse(rls_al),
      .long_press_pulse(lng_al), .repeat_pulse(rpt_al)
   );

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_main(input string tag, input logic [3:0] l, input logic [3:0] p,
                           input logic [3:0] r, input logic [3:0] lp, input logic [3:0] rp);
      chk({tag, " level"}, lvl, l);
      chk({tag, " press"}, prs, p);
      chk({tag, " release"}, rls, r);
      chk({tag, " long"}, lng, lp);
      chk({tag, " repeat"}, rpt, rp);
   endtask

   task automatic chk_al(input string tag, input logic [3:0] l, input logic [3:0] p);
      chk({tag, " al_level"}, lvl_al, l);
      chk({tag, " al_press"}, prs_al, p);
      chk({tag, " al_release"}, rls_al, 4'b0000);
      chk({tag, " al_long"}, lng_al, 4'b0000);
      chk({tag, " al_repeat"}, rpt_al, 4'b0000);
   endtask

   task automatic add(input int n, input logic [3:0] b, input logic [3:0] l,
                      input logic [3:0] p, input logic [3:0] r);
      vec_t v;
      v.btn = b;
      v.lvl = l;
      v.prs = p;
      v.rls = r;
      repeat (n) vecs.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Row i: input applied before edge i, outputs checked after edge i.
      add(5, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      add(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
      add(1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add(5, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      for (int j = 0; j < 3; j++) begin
         add(3, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
         add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      end
      add(5, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
      add(1, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
      add(1, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
      add(5, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
      add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(5, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
      add(1, 4'b1000, 4'b1000, 4'b1000, 4'b0000);
      add(2, 4'b1000, 4'b1000, 4'b0000, 4'b0000);
      add(5, 4'b0001, 4'b1000, 4'b0000, 4'b0000);
      add(1, 4'b0001, 4'b0001, 4'b0001, 4'b1000);
      add(1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add(5, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      rst    = 1'b1;
      btn    = 4'b0000;
      btn_al = 4'b1111;
      repeat (3) @(negedge clk);
      chk_main("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      chk_al("reset", 4'b0000, 4'b0000);
      rst = 1'b0;
      repeat (3) step();

      for (int i = 0; i < vecs.size(); i++) begin
         btn = vecs[i].btn;
         step();
         chk_main($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prs, vecs[i].rls,
                  4'b0000, 4'b0000);
      end

      // Long press and auto-repeat on ch2; release is sampled at c=45.
      btn = 4'b0100;
      for (int c = 0; c <= 60; c++) begin
         if (c == 45) btn = 4'b0000;
         step();
         chk_main($sformatf("hold c%0d", c),
                  (c >= 5 && c < 50) ? 4'b0100 : 4'b0000,
                  (c == 5)  ? 4'b0100 : 4'b0000,
                  (c == 50) ? 4'b0100 : 4'b0000,
                  (c == 25) ? 4'b0100 : 4'b0000,
                  (c == 30 || c == 35 || c == 40 || c == 45) ? 4'b0100 : 4'b0000);
      end

      // Reset while a repeat pulse is high.
      btn = 4'b0100;
      for (int c = 0; c <= 30; c++) step();
      chk("prereset repeat", rpt, 4'b0100);
      chk("prereset level", lvl, 4'b0100);
      #2 rst = 1'b1;
      #1;
      chk_main("rst async", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      for (int c = 0; c < 2; c++) begin
         step();
         chk_main($sformatf("rst held%0d", c), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      end
      rst = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         step();
         chk_main($sformatf("post rst c%0d", c),
                  (c >= 6) ? 4'b0100 : 4'b0000,
                  (c == 6)  ? 4'b0100 : 4'b0000,
                  4'b0000,
                  (c == 26) ? 4'b0100 : 4'b0000,
                  4'b0000);
      end

      // Active-low instance: idle-high pins must stay quiet, then bit 0 pressed.
      btn = 4'b0000;
      for (int c = 0; c < 6; c++) begin
         step();
         chk_al($sformatf("al idle%0d", c), 4'b0000, 4'b0000);
      end
      btn_al = 4'b1110;
      for (int c = 0; c <= 7; c++) begin
         step();
         chk_al($sformatf("al c%0d", c),
                (c >= 5) ? 4'b0001 : 4'b0000,
                (c == 5) ? 4'b0001 : 4'b0000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
